// File: rtl/gemm_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : gemm_stream_engine
// Purpose  : Sequential signed GEMM, R = alpha*(A x B) + beta*C, one MAC per
//            clock. A is MxK, B is KxN, C and R are MxN. Results stream out
//            row-major over a valid/ready port, followed by a one-cycle done.
// Ports    : iclk/irst_n        clock, asynchronous active-low reset
//            istart             start request, sampled in IDLE only
//            ialpha/ibeta       scale factors, latched on accepted start
//            ia/ib/ic_matrix    operand matrices, latched on accepted start
//            oresult/orow/ocol  current result element and its coordinates
//            ovalid/iready      result handshake
//            obusy              high while computing or streaming
//            odone              one-cycle pulse after the last transfer
//            osat               sticky clamp flag (GEMM_SATURATE_EN only)
// Macro    : GEMM_SATURATE_EN   clamp results instead of wrapping, add osat
// Revision : 1.0  initial release
// ============================================================================
module gemm_stream_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int M          = 4,
  parameter int N          = 4,
  parameter int K          = 4
) (
  input  logic                                 iclk,
  input  logic                                 irst_n,
  input  logic                                 istart,
  input  logic signed [DATA_WIDTH-1:0]         ialpha,
  input  logic signed [DATA_WIDTH-1:0]         ibeta,
  input  logic signed [DATA_WIDTH-1:0]         ia_matrix [0:M-1][0:K-1],
  input  logic signed [DATA_WIDTH-1:0]         ib_matrix [0:K-1][0:N-1],
  input  logic signed [DATA_WIDTH-1:0]         ic_matrix [0:M-1][0:N-1],
  output logic signed [DATA_WIDTH-1:0]         oresult,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] orow,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] ocol,
  output logic                                 ovalid,
  input  logic                                 iready,
  output logic                                 obusy,
  output logic                                 odone
`ifdef GEMM_SATURATE_EN
  ,
  output logic                                 osat
`endif
);

  localparam int RW    = (M > 1) ? $clog2(M) : 1;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  // K products of 2*DATA_WIDTH bits plus a sign guard bit never overflow.
  localparam int ACC_W = 2*DATA_WIDTH + $clog2(K) + 1;
  // alpha*dot + beta*c at full precision.
  localparam int FW    = DATA_WIDTH + ACC_W + 1;

  localparam logic [RW-1:0] M_LAST = RW'(M-1);
  localparam logic [CW-1:0] N_LAST = CW'(N-1);
  localparam logic [KW-1:0] K_LAST = KW'(K-1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_OUTPUT  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] alpha_q, alpha_d;
  logic signed [DATA_WIDTH-1:0] beta_q,  beta_d;
  logic signed [DATA_WIDTH-1:0] a_q [0:M-1][0:K-1];
  logic signed [DATA_WIDTH-1:0] a_d [0:M-1][0:K-1];
  logic signed [DATA_WIDTH-1:0] b_q [0:K-1][0:N-1];
  logic signed [DATA_WIDTH-1:0] b_d [0:K-1][0:N-1];
  logic signed [DATA_WIDTH-1:0] c_q [0:M-1][0:N-1];
  logic signed [DATA_WIDTH-1:0] c_d [0:M-1][0:N-1];
  logic signed [DATA_WIDTH-1:0] r_q [0:M-1][0:N-1];
  logic signed [DATA_WIDTH-1:0] r_d [0:M-1][0:N-1];
  logic [RW-1:0]                i_q, i_d, orow_q, orow_d;
  logic [CW-1:0]                j_q, j_d, ocol_q, ocol_d;
  logic [KW-1:0]                k_q, k_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]        dot;
  logic signed [DATA_WIDTH-1:0]   fin_val;

`ifdef GEMM_SATURATE_EN
  localparam logic signed [FW-1:0] SAT_MAX = {{(FW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [FW-1:0] SAT_MIN = ~SAT_MAX;
  logic signed [FW-1:0] full;
  logic                 fin_clamp;
  logic                 sat_q, sat_d;
`endif

  // Datapath: one MAC this cycle; dot already includes it so the final
  // element can be formed in the same cycle as the last product.
  always_comb begin
    prod = (2*DATA_WIDTH)'(a_q[i_q][k_q]) * (2*DATA_WIDTH)'(b_q[k_q][j_q]);
    dot  = acc_q + ACC_W'(prod);
`ifdef GEMM_SATURATE_EN
    full      = FW'(alpha_q) * FW'(dot) + FW'(beta_q) * FW'(c_q[i_q][j_q]);
    fin_clamp = (full > SAT_MAX) || (full < SAT_MIN);
    if (full > SAT_MAX)      fin_val = SAT_MAX[DATA_WIDTH-1:0];
    else if (full < SAT_MIN) fin_val = SAT_MIN[DATA_WIDTH-1:0];
    else                     fin_val = full[DATA_WIDTH-1:0];
`else
    fin_val = DATA_WIDTH'(FW'(alpha_q) * FW'(dot) + FW'(beta_q) * FW'(c_q[i_q][j_q]));
`endif
  end

  always_comb begin
    state_d = state_q;
    alpha_d = alpha_q;
    beta_d  = beta_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    r_d     = r_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
`ifdef GEMM_SATURATE_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (istart) begin
          state_d = S_COMPUTE;
          alpha_d = ialpha;
          beta_d  = ibeta;
          a_d     = ia_matrix;
          b_d     = ib_matrix;
          c_d     = ic_matrix;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
`ifdef GEMM_SATURATE_EN
          sat_d   = 1'b0;
`endif
        end
      end
      S_COMPUTE: begin
        if (k_q == K_LAST) begin
          r_d[i_q][j_q] = fin_val;
          acc_d         = '0;
          k_d           = '0;
`ifdef GEMM_SATURATE_EN
          sat_d         = sat_q | fin_clamp;
`endif
          if (j_q == N_LAST) begin
            j_d = '0;
            if (i_q == M_LAST) begin
              i_d     = '0;
              orow_d  = '0;
              ocol_d  = '0;
              state_d = S_OUTPUT;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          acc_d = dot;
          k_d   = k_q + 1'b1;
        end
      end
      S_OUTPUT: begin
        // Coordinates only move on a transfer, so a stalled sink sees a
        // stable element.
        if (iready) begin
          if (ocol_q == N_LAST) begin
            ocol_d = '0;
            if (orow_q == M_LAST) begin
              orow_d  = '0;
              state_d = S_DONE;
            end else begin
              orow_d = orow_q + 1'b1;
            end
          end else begin
            ocol_d = ocol_q + 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= S_IDLE;
      alpha_q <= '0;
      beta_q  <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      c_q     <= '{default: '0};
      r_q     <= '{default: '0};
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
`ifdef GEMM_SATURATE_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      alpha_q <= alpha_d;
      beta_q  <= beta_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      r_q     <= r_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
`ifdef GEMM_SATURATE_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign ovalid  = (state_q == S_OUTPUT);
  assign obusy   = (state_q == S_COMPUTE) || (state_q == S_OUTPUT);
  assign odone   = (state_q == S_DONE);
  assign orow    = orow_q;
  assign ocol    = ocol_q;
  assign oresult = (state_q == S_OUTPUT) ? r_q[orow_q][ocol_q] : '0;
`ifdef GEMM_SATURATE_EN
  assign osat    = sat_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gemm_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_gemm_stream_engine
// Purpose  : Scoreboard bench for gemm_stream_engine. Three instances:
//            A 16-bit 4x4x4, B 8-bit 2x3x4 (overflow cases), C 8-bit 1x1x1.
//            Expected elements are computed with plain integer arithmetic
//            when a job is started and popped by per-instance monitors.
// Revision : 1.0  initial release
// ============================================================================
module tb_gemm_stream_engine;

  localparam int AW = 16, AM = 4, AN = 4, AK = 4;
  localparam int BW = 8,  BM = 2, BN = 3, BK = 4;
  localparam int CWD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { longint val; int row; int col; } exp_t;
  exp_t exp_a[$], exp_b[$], exp_c[$];
  exp_t ea, eb, ec;
`ifdef GEMM_SATURATE_EN
  bit sat_a[$], sat_b[$], sat_c[$];
  logic a_osat, b_osat, c_osat;
`endif

  // Job description shared by all instances (flattened row-major).
  longint ma[16], mb[16], mc[16];
  longint g_alpha, g_beta;

  // ---------------- instance A ----------------
  logic a_start = 0, a_iready = 1;
  logic signed [AW-1:0] a_alpha = '0, a_beta = '0;
  logic signed [AW-1:0] a_ia [0:AM-1][0:AK-1];
  logic signed [AW-1:0] a_ib [0:AK-1][0:AN-1];
  logic signed [AW-1:0] a_ic [0:AM-1][0:AN-1];
  logic signed [AW-1:0] a_res;
  logic [1:0] a_row, a_col;
  logic a_valid, a_busy, a_done;

  gemm_stream_engine #(.DATA_WIDTH(AW), .M(AM), .N(AN), .K(AK)) u_dut_a (
    .iclk(clk), .irst_n(rst_n), .istart(a_start), .ialpha(a_alpha), .ibeta(a_beta),
    .ia_matrix(a_ia), .ib_matrix(a_ib), .ic_matrix(a_ic),
    .oresult(a_res), .orow(a_row), .ocol(a_col), .ovalid(a_valid), .iready(a_iready),
    .obusy(a_busy), .odone(a_done)
`ifdef GEMM_SATURATE_EN
    , .osat(a_osat)
`endif
  );

  // ---------------- instance B ----------------
  logic b_start = 0, b_iready = 1;
  logic signed [BW-1:0] b_alpha = '0, b_beta = '0;
  logic signed [BW-1:0] b_ia [0:BM-1][0:BK-1];
  logic signed [BW-1:0] b_ib [0:BK-1][0:BN-1];
  logic signed [BW-1:0] b_ic [0:BM-1][0:BN-1];
  logic signed [BW-1:0] b_res;
  logic [0:0] b_row;
  logic [1:0] b_col;
  logic b_valid, b_busy, b_done;

  gemm_stream_engine #(.DATA_WIDTH(BW), .M(BM), .N(BN), .K(BK)) u_dut_b (
    .iclk(clk), .irst_n(rst_n), .istart(b_start), .ialpha(b_alpha), .ibeta(b_beta),
    .ia_matrix(b_ia), .ib_matrix(b_ib), .ic_matrix(b_ic),
    .oresult(b_res), .orow(b_row), .ocol(b_col), .ovalid(b_valid), .iready(b_iready),
    .obusy(b_busy), .odone(b_done)
`ifdef GEMM_SATURATE_EN
    , .osat(b_osat)
`endif
  );

  // ---------------- instance C ----------------
  logic c_start = 0, c_iready = 1;
  logic signed [CWD-1:0] c_alpha = '0, c_beta = '0;
  logic signed [CWD-1:0] c_ia [0:0][0:0];
  logic signed [CWD-1:0] c_ib [0:0][0:0];
  logic signed [CWD-1:0] c_ic [0:0][0:0];
  logic signed [CWD-1:0] c_res;
  logic [0:0] c_row, c_col;
  logic c_valid, c_busy, c_done;

  gemm_stream_engine #(.DATA_WIDTH(CWD), .M(1), .N(1), .K(1)) u_dut_c (
    .iclk(clk), .irst_n(rst_n), .istart(c_start), .ialpha(c_alpha), .ibeta(c_beta),
    .ia_matrix(c_ia), .ib_matrix(c_ib), .ic_matrix(c_ic),
    .oresult(c_res), .orow(c_row), .ocol(c_col), .ovalid(c_valid), .iready(c_iready),
    .obusy(c_busy), .odone(c_done)
`ifdef GEMM_SATURATE_EN
    , .osat(c_osat)
`endif
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint rnd(input int dw);
    longint lim = longint'(1) << (dw - 1);
    return longint'($urandom_range(0, 32'(2*lim - 1))) - lim;
  endfunction

  function automatic longint fin_model(input longint full, input int dw, inout bit sat);
    longint lim = longint'(1) << (dw - 1);
    longint v;
`ifdef GEMM_SATURATE_EN
    if (full > lim - 1) begin sat = 1'b1; v = lim - 1; end
    else if (full < -lim) begin sat = 1'b1; v = -lim; end
    else v = full;
`else
    v = full & ((lim << 1) - 1);
    if (v >= lim) v = v - (lim << 1);
`endif
    return v;
  endfunction

  // Reference: R[r][c] = fin(alpha * sum_x A[r][x]*B[x][c] + beta * C[r][c]).
  task automatic model(input int which, input int dw, input int m, input int n, input int k);
    bit sat = 1'b0;
    exp_t e;
    longint s;
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        s = 0;
        for (int x = 0; x < k; x++) s += ma[r*k + x] * mb[x*n + c];
        e.val = fin_model(g_alpha * s + g_beta * mc[r*n + c], dw, sat);
        e.row = r;
        e.col = c;
        case (which)
          0: exp_a.push_back(e);
          1: exp_b.push_back(e);
          default: exp_c.push_back(e);
        endcase
      end
    end
`ifdef GEMM_SATURATE_EN
    case (which)
      0: sat_a.push_back(sat);
      1: sat_b.push_back(sat);
      default: sat_c.push_back(sat);
    endcase
`endif
  endtask

  task automatic fill_rand(input int dw, input int m, input int n, input int k);
    for (int x = 0; x < m*k; x++) ma[x] = rnd(dw);
    for (int x = 0; x < k*n; x++) mb[x] = rnd(dw);
    for (int x = 0; x < m*n; x++) mc[x] = rnd(dw);
    g_alpha = rnd(dw);
    g_beta  = rnd(dw);
  endtask

  task automatic fill_const(input longint av, input longint bv, input longint cv,
                            input longint al, input longint be);
    for (int x = 0; x < 16; x++) begin ma[x] = av; mb[x] = bv; mc[x] = cv; end
    g_alpha = al;
    g_beta  = be;
  endtask

  task automatic fill_identity();
    for (int x = 0; x < 16; x++) begin
      ma[x] = ((x / AK) == (x % AK)) ? 1 : 0;
      mb[x] = x + 1;
      mc[x] = 0;
    end
    g_alpha = 1;
    g_beta  = 0;
  endtask

  // ---------------- job drivers (called when the DUT is idle) ----------------
  task automatic load_a();
    for (int r = 0; r < AM; r++) for (int c = 0; c < AK; c++) a_ia[r][c] = AW'(ma[r*AK + c]);
    for (int r = 0; r < AK; r++) for (int c = 0; c < AN; c++) a_ib[r][c] = AW'(mb[r*AN + c]);
    for (int r = 0; r < AM; r++) for (int c = 0; c < AN; c++) a_ic[r][c] = AW'(mc[r*AN + c]);
    a_alpha = AW'(g_alpha);
    a_beta  = AW'(g_beta);
    model(0, AW, AM, AN, AK);
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    // Operands were latched; scramble the ports to prove it.
    for (int r = 0; r < AM; r++) for (int c = 0; c < AK; c++) a_ia[r][c] = AW'(rnd(AW));
    a_alpha = AW'(rnd(AW));
    a_beta  = AW'(rnd(AW));
  endtask

  task automatic finish_a(input bit check_lat, input bit poke);
    int cnt = 1;
    while (!a_valid && cnt < 500) begin
      a_start = poke && (cnt == 10);
      @(posedge clk); #1;
      cnt++;
    end
    a_start = 1'b0;
    if (check_lat) check("latency_a", cnt, AM*AN*AK + 1);
    cnt = 0;
    while (!a_done && cnt < 2000) begin
      a_start = poke && (cnt == 2);
      @(posedge clk); #1;
      cnt++;
    end
    a_start = 1'b0;
    check("done_seen_a", a_done, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_b(input bit check_lat);
    int cnt = 1;
    for (int r = 0; r < BM; r++) for (int c = 0; c < BK; c++) b_ia[r][c] = BW'(ma[r*BK + c]);
    for (int r = 0; r < BK; r++) for (int c = 0; c < BN; c++) b_ib[r][c] = BW'(mb[r*BN + c]);
    for (int r = 0; r < BM; r++) for (int c = 0; c < BN; c++) b_ic[r][c] = BW'(mc[r*BN + c]);
    b_alpha = BW'(g_alpha);
    b_beta  = BW'(g_beta);
    model(1, BW, BM, BN, BK);
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    while (!b_valid && cnt < 500) begin @(posedge clk); #1; cnt++; end
    if (check_lat) check("latency_b", cnt, BM*BN*BK + 1);
    cnt = 0;
    while (!b_done && cnt < 2000) begin @(posedge clk); #1; cnt++; end
    check("done_seen_b", b_done, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_c();
    int cnt = 1;
    c_ia[0][0] = CWD'(ma[0]);
    c_ib[0][0] = CWD'(mb[0]);
    c_ic[0][0] = CWD'(mc[0]);
    c_alpha = CWD'(g_alpha);
    c_beta  = CWD'(g_beta);
    model(2, CWD, 1, 1, 1);
    c_start = 1'b1;
    @(posedge clk); #1;
    c_start = 1'b0;
    while (!c_valid && cnt < 500) begin @(posedge clk); #1; cnt++; end
    check("latency_c", cnt, 2);
    cnt = 0;
    while (!c_done && cnt < 2000) begin @(posedge clk); #1; cnt++; end
    check("done_seen_c", c_done, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- sink backpressure ----------------
  bit bp_a = 0, bp_b = 0, bp_c = 0;
  initial forever begin
    @(posedge clk); #1;
    a_iready = bp_a ? 1'($urandom_range(0, 1)) : 1'b1;
    b_iready = bp_b ? 1'($urandom_range(0, 1)) : 1'b1;
    c_iready = bp_c ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitors ----------------
  bit a_hold = 0, b_hold = 0;
  logic signed [AW-1:0] a_hres;
  logic [1:0] a_hrow, a_hcol;
  logic signed [BW-1:0] b_hres;
  logic [0:0] b_hrow;
  logic [1:0] b_hcol;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_hold = 0;
    end else begin
      if (a_valid) begin
        if (a_hold) begin
          check("stable_res_a", a_res, a_hres);
          check("stable_pos_a", {a_row, a_col}, {a_hrow, a_hcol});
        end
        if (a_iready) begin
          a_hold = 0;
          check("avail_a", exp_a.size() > 0, 1);
          if (exp_a.size() > 0) begin
            ea = exp_a.pop_front();
            check("res_a", a_res, ea.val);
            check("row_a", a_row, ea.row);
            check("col_a", a_col, ea.col);
          end
        end else begin
          a_hold = 1;
          a_hres = a_res; a_hrow = a_row; a_hcol = a_col;
        end
      end else a_hold = 0;
      if (a_done) begin
        check("drain_a", exp_a.size(), 0);
`ifdef GEMM_SATURATE_EN
        if (sat_a.size() > 0) check("osat_a", a_osat, sat_a.pop_front());
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_hold = 0;
    end else begin
      if (b_valid) begin
        if (b_hold) begin
          check("stable_res_b", b_res, b_hres);
          check("stable_pos_b", {b_row, b_col}, {b_hrow, b_hcol});
        end
        if (b_iready) begin
          b_hold = 0;
          check("avail_b", exp_b.size() > 0, 1);
          if (exp_b.size() > 0) begin
            eb = exp_b.pop_front();
            check("res_b", b_res, eb.val);
            check("row_b", b_row, eb.row);
            check("col_b", b_col, eb.col);
          end
        end else begin
          b_hold = 1;
          b_hres = b_res; b_hrow = b_row; b_hcol = b_col;
        end
      end else b_hold = 0;
      if (b_done) begin
        check("drain_b", exp_b.size(), 0);
`ifdef GEMM_SATURATE_EN
        if (sat_b.size() > 0) check("osat_b", b_osat, sat_b.pop_front());
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (c_valid && c_iready) begin
        check("avail_c", exp_c.size() > 0, 1);
        if (exp_c.size() > 0) begin
          ec = exp_c.pop_front();
          check("res_c", c_res, ec.val);
          check("pos_c", {c_row, c_col}, 2'b00);
        end
      end
      if (c_done) begin
        check("drain_c", exp_c.size(), 0);
`ifdef GEMM_SATURATE_EN
        if (sat_c.size() > 0) check("osat_c", c_osat, sat_c.pop_front());
`endif
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int r = 0; r < AM; r++) for (int c = 0; c < AK; c++) begin
      a_ia[r][c] = '0; a_ib[r][c] = '0; a_ic[r][c] = '0;
    end
    for (int r = 0; r < BM; r++) for (int c = 0; c < BK; c++) b_ia[r][c] = '0;
    for (int r = 0; r < BK; r++) for (int c = 0; c < BN; c++) b_ib[r][c] = '0;
    for (int r = 0; r < BM; r++) for (int c = 0; c < BN; c++) b_ic[r][c] = '0;
    c_ia[0][0] = '0; c_ib[0][0] = '0; c_ic[0][0] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy_a",  a_busy,  0);
    check("rst_valid_a", a_valid, 0);
    check("rst_done_a",  a_done,  0);
    check("rst_res_a",   a_res,   0);
    check("rst_pos_a",   {a_row, a_col}, 0);
    check("rst_valid_b", b_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity: streams 1..16 after M*N*K+1 cycles.
    fill_identity();
    load_a(); finish_a(1'b1, 1'b0);
    // Beta only: every element 15.
    fill_const(0, 0, 5, 1, 3);
    for (int x = 0; x < 16; x++) mb[x] = rnd(AW);
    load_a(); finish_a(1'b0, 1'b0);
    // Signed: every element -20.
    fill_const(-1, 2, 1, 2, -4);
    load_a(); finish_a(1'b0, 1'b0);
    // Backpressure with the identity job.
    bp_a = 1;
    fill_identity();
    load_a(); finish_a(1'b1, 1'b0);
    // Random jobs under backpressure.
    repeat (4) begin
      fill_rand(AW, AM, AN, AK);
      load_a(); finish_a(1'b0, 1'b0);
    end
    bp_a = 0;

    // Overflow on the 8-bit engine: acc = 4*127*127 = 64516.
    fill_const(127, 127, 0, 1, 0);
    for (int x = 0; x < 16; x++) mc[x] = rnd(BW);
    run_b(1'b1);
    bp_b = 1;
    repeat (4) begin
      fill_rand(BW, BM, BN, BK);
      run_b(1'b0);
    end
    // Negative clamp / wrap: A=127, B=-128.
    fill_const(127, -128, 0, 1, 0);
    run_b(1'b0);
    bp_b = 0;

    // Degenerate 1x1x1 engine.
    repeat (3) begin
      fill_rand(CWD, 1, 1, 1);
      run_c();
    end
    bp_c = 1;
    fill_rand(CWD, 1, 1, 1);
    run_c();
    bp_c = 0;

    // Reset in the middle of COMPUTE aborts the job.
    fill_identity();
    load_a();
    repeat (9) begin @(posedge clk); #1; end
    check("busy_before_rst", a_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",  a_busy,  0);
    check("arst_valid", a_valid, 0);
    check("arst_done",  a_done,  0);
    check("arst_res",   a_res,   0);
    check("arst_pos",   {a_row, a_col}, 0);
    exp_a.delete();
`ifdef GEMM_SATURATE_EN
    sat_a.delete();
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    // Rerun identity with stray istart pulses during COMPUTE and OUTPUT.
    fill_identity();
    load_a(); finish_a(1'b1, 1'b1);
    check("idle_after_rerun", a_busy, 0);

    repeat (5) @(posedge clk);
    check("leftover_a", exp_a.size(), 0);
    check("leftover_b", exp_b.size(), 0);
    check("leftover_c", exp_c.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
